// File: rtl/rbm_pkg.sv
// Shared types and constants for the RBM iteration controller.
// FSM state encoding plus signed saturation bounds derived from an accumulator width.
// Pure declarations; no logic, no latency, no flow control.
`timescale 1ns/1ps
package rbm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Bounds are computed in a 64-bit signed domain and narrowed by the user.
  function automatic logic signed [63:0] acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

  // Bounds for the default 16-bit accumulator.
  localparam int                    ACC_W_DEF   = 16;
  localparam logic signed [15:0]    ACC_MAX_DEF = 16'(acc_max(ACC_W_DEF));
  localparam logic signed [15:0]    ACC_MIN_DEF = 16'(acc_min(ACC_W_DEF));

endpackage

// File: rtl/rbm_iter_controller_sat_acc.sv
// One saturating signed accumulator channel: acc <= sat(acc + sext(din)).
// Latency: one cycle from en to updated acc; sum is also exposed combinationally.
// No flow control; clear has priority over en.
`timescale 1ns/1ps
module rbm_sat_acc
  import rbm_pkg::*;
#(
  parameter int BITLENGTH = 12,
  parameter int ACC_W     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [BITLENGTH-1:0] din,
  output logic signed [ACC_W-1:0]     acc,
  output logic signed [ACC_W-1:0]     acc_sum
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic signed [ACC_W:0] sum_wide;

  // One guard bit detects overflow; clamp toward the sign of the true sum.
  always_comb begin
    sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(din);
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sum = sum_wide[ACC_W-1:0];
    end
  end

  // Accumulator register: cleared per job, updated once per iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/rbm_iter_controller.sv
// Iterates a layer chain iter_num times, saturating-accumulating each channel, then reports argmax.
// Latency: 4 cycles + layer latency per iteration; iter_num==0 reaches DONE on the accept edge.
// Result held in DONE until out_ready; in_ready only in IDLE. Optional margin stop: RBM_EARLY_STOP_EN.
`timescale 1ns/1ps
module rbm_iter_controller
  import rbm_pkg::*;
#(
  parameter int BITLENGTH = 12,
  parameter int OUT_DIM   = 2,
  parameter int ACC_W     = 16,
  parameter int ITER_W    = 16,
  parameter int MARGIN    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ITER_W-1:0]             iter_num,
  output logic                          layer_rst,
  output logic                          layer_start,
  input  logic                          layer_done,
  input  logic [OUT_DIM*BITLENGTH-1:0]  layer_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_DIM*ACC_W-1:0]      acc_out,
  output logic [$clog2(OUT_DIM)-1:0]    class_idx,
  output logic [ITER_W-1:0]             iter_done,
  output logic                          early_stop
);

  localparam int CW = $clog2(OUT_DIM);

  state_t                   state, state_nxt;
  logic [ITER_W-1:0]        iter_lat;
  logic [ITER_W-1:0]        cnt;
  logic [ITER_W-1:0]        cnt_inc;
  logic                     last_iter;
  logic [OUT_DIM*BITLENGTH-1:0] cap;
  logic                     acc_clr;
  logic                     acc_en;
  logic signed [ACC_W-1:0]  acc_q [OUT_DIM];
  logic signed [ACC_W-1:0]  acc_n [OUT_DIM];
  logic [CW-1:0]            best_idx;
  logic                     stop_margin;

  assign cnt_inc   = cnt + ITER_W'(1);
  assign last_iter = (cnt_inc == iter_lat);

  genvar g;
  generate
    for (g = 0; g < OUT_DIM; g++) begin : g_ch
      rbm_sat_acc #(
        .BITLENGTH (BITLENGTH),
        .ACC_W     (ACC_W)
      ) u_acc (
        .clock   (clock),
        .reset   (reset),
        .clear   (acc_clr),
        .en      (acc_en),
        .din     (cap[g*BITLENGTH +: BITLENGTH]),
        .acc     (acc_q[g]),
        .acc_sum (acc_n[g])
      );
      assign acc_out[g*ACC_W +: ACC_W] = acc_q[g];
    end
  endgenerate

  // Argmax over the post-add values so class_idx is valid on entry to DONE; strict > keeps lowest index on ties.
  always_comb begin
    logic signed [ACC_W-1:0] best_v;
    best_v   = acc_n[0];
    best_idx = '0;
    for (int i = 1; i < OUT_DIM; i++) begin
      if (acc_n[i] > best_v) begin
        best_v   = acc_n[i];
        best_idx = CW'(i);
      end
    end
  end

`ifdef RBM_EARLY_STOP_EN
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));
  logic signed [ACC_W-1:0] top_v, sec_v;
  logic signed [ACC_W:0]   lead;

  // Lead of the largest post-add accumulator over the runner-up, compared against MARGIN.
  always_comb begin
    top_v = acc_n[0];
    sec_v = ACC_MIN;
    for (int i = 1; i < OUT_DIM; i++) begin
      if (acc_n[i] > top_v) begin
        sec_v = top_v;
        top_v = acc_n[i];
      end else if (acc_n[i] > sec_v) begin
        sec_v = acc_n[i];
      end
    end
    lead        = (ACC_W+1)'(top_v) - (ACC_W+1)'(sec_v);
    stop_margin = (lead >= (ACC_W+1)'(MARGIN));
  end

  // early_stop marks a job that finished before its iteration budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      early_stop <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      early_stop <= 1'b0;
    end else if (state == ACCUM && state_nxt == DONE) begin
      early_stop <= ~last_iter;
    end
  end
`else
  assign stop_margin = 1'b0;
  assign early_stop  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and accumulator controls.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_clr   = 1'b1;
          state_nxt = (iter_num == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (layer_done) state_nxt = ACCUM;
      ACCUM: begin
        acc_en    = 1'b1;
        state_nxt = (last_iter || stop_margin) ? DONE : CLEAR;
      end
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready    = (state == IDLE);
  assign layer_rst   = (state == CLEAR);
  assign layer_start = (state == START);
  assign out_valid   = (state == DONE);

  // Job bookkeeping, layer capture and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iter_lat  <= '0;
      cnt       <= '0;
      cap       <= '0;
      class_idx <= '0;
      iter_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            iter_lat  <= iter_num;
            cnt       <= '0;
            class_idx <= '0;
            iter_done <= '0;
          end
        end
        WAIT: begin
          if (layer_done) cap <= layer_out;
        end
        ACCUM: begin
          cnt <= cnt_inc;
          if (state_nxt == DONE) begin
            class_idx <= best_idx;
            iter_done <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rbm_iter_controller.md
RBM_ITER_CONTROLLER -- requirements
Module: rbm_iter_controller

Interface
REQ-001 The block SHALL have parameter BITLENGTH, default 12, width of one signed layer output element.
REQ-002 The block SHALL have parameter OUT_DIM, default 2, number of output channels (classes), 2..16.
REQ-003 The block SHALL have parameter ACC_W, default 16, width of each signed accumulator, ACC_W >= BITLENGTH.
REQ-004 The block SHALL have parameter ITER_W, default 16, width of the iteration-count input.
REQ-005 The block SHALL have parameter MARGIN, default 64, early-stop lead threshold in accumulator LSBs.
REQ-006 The block SHALL have these ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  job request.
- in_ready  out  1  block can accept a job.
- iter_num  in  ITER_W  iteration count, sampled at accept.
- layer_rst  out  1  one-cycle reset pulse to the layer chain.
- layer_start  out  1  one-cycle start pulse to the layer chain.
- layer_done  in  1  layer chain result valid.
- layer_out  in  OUT_DIM*BITLENGTH  packed signed layer results, channel 0 in the LSBs.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- acc_out  out  OUT_DIM*ACC_W  packed signed accumulators.
- class_idx  out  $clog2(OUT_DIM)  argmax channel.
- iter_done  out  ITER_W  iterations actually run.
- early_stop  out  1  job ended by margin.

Function
REQ-007 The FSM SHALL have exactly these states: IDLE, CLEAR, START, WAIT, ACCUM, DONE.
REQ-008 IDLE: in_ready=1; in_valid=1 SHALL latch iter_num, zero all accumulators and the counter, and go to CLEAR; if iter_num==0, go to DONE instead.
REQ-009 CLEAR SHALL assert layer_rst for exactly one cycle, then go to START.
REQ-010 START SHALL assert layer_start for exactly one cycle, then go to WAIT.
REQ-011 WAIT SHALL hold until layer_done=1, then capture layer_out and go to ACCUM.
REQ-012 layer_done SHALL be ignored in every state except WAIT.
REQ-013 ACCUM SHALL:
- add each sign-extended channel to its accumulator with saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
- increment the counter;
- go to DONE if counter==latched iter_num, else go to CLEAR.
REQ-014 The minimum iteration period SHALL be 4 cycles plus the layer latency.
REQ-015 DONE SHALL assert out_valid, holding acc_out, class_idx, iter_done and early_stop stable until out_ready=1; it SHALL then return to IDLE on the next edge.
REQ-016 class_idx SHALL be the index of the largest accumulator, with the lowest index winning ties; it SHALL be registered at entry to DONE.
REQ-017 in_ready SHALL be 0 in every state except IDLE.
REQ-018 iter_done SHALL equal the counter value at entry to DONE (0 for an iter_num==0 job).

Reset
REQ-019 While reset is asserted, and asynchronously at its assertion, the block SHALL:
- enter IDLE;
- clear accumulators, counter, class_idx, iter_done and early_stop;
- drive out_valid, layer_rst and layer_start to 0.
REQ-020 Reset mid-job SHALL abandon the job with no result emitted; in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-021 With RBM_EARLY_STOP_EN defined, ACCUM SHALL go to DONE with early_stop=1 when the top accumulator minus the second-largest is >= MARGIN, even if the counter < iter_num.
REQ-022 Without RBM_EARLY_STOP_EN, early_stop SHALL be tied 0, the margin logic SHALL be absent, and every job SHALL run exactly iter_num iterations.

Structure
REQ-023 Package rbm_pkg SHALL hold the FSM state enum and the saturation bound constants derived from ACC_W.
REQ-024 A sub-module rbm_sat_acc SHALL implement one saturating signed accumulator channel.
REQ-025 The block SHALL instantiate OUT_DIM copies of rbm_sat_acc via generate.

Verification
REQ-026 Basic accumulation: iter_num=3, layer_out ch0=+10, ch1=-5 every iteration -> acc=(30,-15), class_idx=0, iter_done=3, exactly 3 layer_rst and 3 layer_start pulses.
REQ-027 Zero iterations: iter_num=0 -> out_valid within 2 cycles, acc=(0,0), no layer_rst or layer_start pulses.
REQ-028 Saturation: ACC_W=12, BITLENGTH=12, ch0=2047 for 4 iterations -> acc0=2047, not wrapped; ch1=-2048 -> acc1=-2048.
REQ-029 Tie and backpressure: equal channels -> class_idx=0; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-030 Early stop (with RBM_EARLY_STOP_EN, MARGIN=64): iter_num=100, ch0=40, ch1=0 -> DONE after iteration 2, early_stop=1, iter_done=2; without the macro -> iter_done=100.
REQ-031 Reset mid-job: assert reset in WAIT of iteration 5 -> out_valid never asserts, in_ready=1 after deassertion, and a new job with iter_num=1 completes correctly.
